// File: rtl/ssa_pkg.sv
// Shared definitions for the digit-convolution multiplier: FSM states and
// the coefficient width that holds a full column sum without overflow.
package ssa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    CARRY,
    DONE
  } state_t;

  // A column sums at most N digit products, each below 2^(2*digit_w).
  function automatic int coef_width(input int digit_w, input int n_digits);
    return 2 * digit_w + $clog2(n_digits);
  endfunction

endpackage

// File: rtl/ssa_digit_mac.sv
// One digit-by-digit product accumulated into a convolution coefficient.
module ssa_digit_mac #(
  parameter int DIGIT_W = 2,
  parameter int CW      = 5
) (
  input  logic [DIGIT_W-1:0] a_digit,
  input  logic [DIGIT_W-1:0] b_digit,
  input  logic [CW-1:0]      coef_in,
  output logic [CW-1:0]      coef_out
);

  logic [2*DIGIT_W-1:0] prod;

  assign prod     = (2*DIGIT_W)'(a_digit) * (2*DIGIT_W)'(b_digit);
  assign coef_out = coef_in + CW'(prod);

endmodule

// File: rtl/ssa_conv_mult.sv
// Unsigned multiplier: digit-wise convolution (one product per cycle)
// followed by a carry/recompose pass (one coefficient per cycle).
module ssa_conv_mult
  import ssa_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c,
  output logic               busy
);

  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = coef_width(DIGIT_W, N);
  localparam int NC = 2 * N - 1;
  localparam int PW = 2 * WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [IW-1:0] LAST_IJ = IW'(N - 1);
  localparam logic [KW-1:0] LAST_K  = KW'(NC - 1);

  generate
    if (DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_params
      $error("ssa_conv_mult: WIDTH must be a positive multiple of DIGIT_W");
    end
  endgenerate

  state_t          state_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]   i_reg, j_reg;
  logic [KW-1:0]   k_reg;
  logic [CW-1:0]   coef_reg [NC];
  logic [PW-1:0]   acc_reg, c_reg;
  logic            in_ready_reg, out_valid_reg, busy_reg;

  logic             accept;
  logic [KW-1:0]    sum_idx;
  logic [DIGIT_W-1:0] a_digit, b_digit;
  logic [CW-1:0]    coef_sel, mac_out, coef_k;
  logic [PW-1:0]    term, acc_next;

  assign accept  = in_valid && in_ready_reg && (state_reg == IDLE);
  assign sum_idx = KW'(i_reg) + KW'(j_reg);
  assign a_digit = a_reg[int'(i_reg)*DIGIT_W +: DIGIT_W];
  assign b_digit = b_reg[int'(j_reg)*DIGIT_W +: DIGIT_W];
  assign coef_sel = coef_reg[sum_idx];
  assign coef_k   = coef_reg[k_reg];

  ssa_digit_mac #(
    .DIGIT_W (DIGIT_W),
    .CW      (CW)
  ) u_mac (
    .a_digit  (a_digit),
    .b_digit  (b_digit),
    .coef_in  (coef_sel),
    .coef_out (mac_out)
  );

  // Bits pushed past 2*WIDTH by the shift are zero for any valid product.
  assign term     = PW'(coef_k) << (DIGIT_W * int'(k_reg));
  assign acc_next = acc_reg + term;

  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_coef
      always_ff @(posedge clk) begin
        if (rst || accept) begin
          coef_reg[gi] <= '0;
        end else if (state_reg == CONV && sum_idx == KW'(gi)) begin
          coef_reg[gi] <= mac_out;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      i_reg         <= '0;
      j_reg         <= '0;
      k_reg         <= '0;
      acc_reg       <= '0;
      c_reg         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg        <= a;
            b_reg        <= b;
            i_reg        <= '0;
            j_reg        <= '0;
            acc_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= CONV;
          end
        end
        CONV: begin
          if (j_reg == LAST_IJ) begin
            j_reg <= '0;
            if (i_reg == LAST_IJ) begin
              i_reg     <= '0;
              k_reg     <= '0;
              acc_reg   <= '0;
              state_reg <= CARRY;
            end else begin
              i_reg <= i_reg + 1'b1;
            end
          end else begin
            j_reg <= j_reg + 1'b1;
          end
        end
        CARRY: begin
          acc_reg <= acc_next;
          if (k_reg == LAST_K) begin
            k_reg         <= '0;
            c_reg         <= acc_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign c         = c_reg;

endmodule

// File: tb/tb_ssa_conv_mult.sv
// Bench for ssa_conv_mult: vector table, hold/abort sequences, wide-digit
// variants and random back-to-back traffic checked through a scoreboard.
module tb_ssa_conv_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] c;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] c16;
  logic        in_valid12, in_ready12, out_valid12, out_ready12, busy12;
  logic [11:0] a12, b12;
  logic [23:0] c12;

  ssa_conv_mult u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .busy(busy)
  );

  ssa_conv_mult #(.WIDTH(16), .DIGIT_W(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .c(c16), .busy(busy16)
  );

  ssa_conv_mult #(.WIDTH(12), .DIGIT_W(3)) u_dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid12), .in_ready(in_ready12),
    .a(a12), .b(b12), .out_valid(out_valid12), .out_ready(out_ready12),
    .c(c12), .busy(busy12)
  );

  typedef struct {
    logic [15:0] prod;
    int          t;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  localparam int LAT = 24;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Scoreboard side: compare each new result against the oldest accepted op.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && !ov_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got out_valid=1 c=%0d expected no result", c);
      end else begin
        e = exp_q.pop_front();
        check("product", 32'(c), 32'(e.prod));
        check("latency", 32'(cyc), 32'(e.t + LAT));
      end
    end
    ov_prev = out_valid;
  end

  // Present operands until accepted; push the expectation in the accept cycle.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] texp);
    bit acc_seen = 1'b0;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{prod: texp, t: cyc});
        acc_seen = 1'b1;
        break;
      end
    end
    if (!acc_seen) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   t0;
    bit   seen;
    logic [7:0] ra, rb;

    tbl[0] = '{8'd155, 8'd225, 16'h883B};
    tbl[1] = '{8'd255, 8'd255, 16'hFE01};
    tbl[2] = '{8'd0,   8'd200, 16'd0};
    tbl[3] = '{8'd200, 8'd0,   16'd0};
    tbl[4] = '{8'd1,   8'd1,   16'd1};
    tbl[5] = '{8'd128, 8'd2,   16'd256};
    tbl[6] = '{8'd17,  8'd13,  16'd221};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0;
    in_valid12 = 1'b0; out_ready12 = 1'b1; a12 = '0; b12 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_c", 32'(c), 32'd0);
    @(posedge clk);
    #1;

    // Wider digits, WIDTH=16 DIGIT_W=4.
    in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; t0 = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (in_ready16) begin t0 = cyc; break; end
    end
    @(posedge clk); #1 in_valid16 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid16) break;
    end
    check("w16_product", c16, 32'hFFFE0001);
    check("w16_latency", 32'(cyc), 32'(t0 + LAT));
    @(negedge clk);
    check("w16_busy_after", 32'(busy16), 32'd0);

    // Odd digit width, WIDTH=12 DIGIT_W=3.
    @(posedge clk); #1;
    in_valid12 = 1'b1; a12 = 12'd4095; b12 = 12'd1; t0 = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (in_ready12) begin t0 = cyc; break; end
    end
    @(posedge clk); #1 in_valid12 = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid12) break;
    end
    check("w12_product", 32'(c12), 32'd4095);
    check("w12_latency", 32'(cyc), 32'(t0 + LAT));
    @(negedge clk);
    check("w12_busy_after", 32'(busy12), 32'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      do_op(tbl[v].a, tbl[v].b, tbl[v].prod);
      in_valid = 1'b0;
      @(negedge clk);
      check("busy_in_op", 32'(busy), 32'd1);
      check("in_ready_in_op", 32'(in_ready), 32'd0);
      drain();
    end

    // Consumer stalls: result and flags hold while inputs wiggle.
    out_ready = 1'b0;
    do_op(8'd100, 8'd7, 16'd700);
    in_valid = 1'b0;
    for (int n = 0; n < 60 && !out_valid; n++) @(negedge clk);
    check("hold_reached", 32'(out_valid), 32'd1);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      a = 8'($urandom); b = 8'($urandom); in_valid = ~in_valid;
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_c", 32'(c), 32'd700);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
    check("release_c_kept", 32'(c), 32'd700);
    @(posedge clk); #1;

    // Abort mid-conversion: no result may appear afterwards.
    do_op(8'd77, 8'd99, 16'd7623);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_c", 32'(c), 32'd0);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", 32'(seen), 32'd0);
    @(posedge clk); #1;
    do_op(8'd3, 8'd5, 16'd15);
    in_valid = 1'b0;
    drain();

    // Back-to-back random traffic with in_valid held high.
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_op(ra, rb, 16'(ra) * 16'(rb));
    end
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
